// File: rtl/master_trigger_generator.sv
// Radar master trigger: fixed-width pulses at a programmable repetition interval,
// as a finite burst or continuously, with abort, clamping and a done strobe.
//
// Ports:
//   ipClk, ipReset              clock, synchronous active-high reset
//   ipEnable, ipStart, ipStop   master enable, start strobe, abort strobe
//   ipPeriod, ipLength          repetition interval and high time, in cycles
//   ipBurstCount                pulses per burst, 0 = continuous
//   opTrigger, opBusy           registered trigger, high while running
//   opPulseCount, opDone        pulses since last start, burst-complete strobe
module master_trigger_generator #(
    parameter int PERIOD_WIDTH = 32,
    parameter int LENGTH_WIDTH = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic                    ipEnable,
    input  logic                    ipStart,
    input  logic                    ipStop,
    input  logic [PERIOD_WIDTH-1:0] ipPeriod,
    input  logic [LENGTH_WIDTH-1:0] ipLength,
    input  logic [COUNT_WIDTH-1:0]  ipBurstCount,
    output logic                    opTrigger,
    output logic                    opBusy,
    output logic [COUNT_WIDTH-1:0]  opPulseCount,
    output logic                    opDone
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state, state_n;
    logic [PERIOD_WIDTH-1:0] phase, phase_n;
    logic [PERIOD_WIDTH-1:0] period, period_n;
    logic [PERIOD_WIDTH-1:0] length, length_n;
    logic [COUNT_WIDTH-1:0]  burst, burst_n;
    logic [COUNT_WIDTH-1:0]  count_n;
    logic                    trigger_n;
    logic                    busy_n;
    logic                    done_n;

    logic [PERIOD_WIDTH-1:0] start_period;
    logic [PERIOD_WIDTH-1:0] start_length;
    logic [PERIOD_WIDTH-1:0] length_ext;
    logic [PERIOD_WIDTH-1:0] phase_inc;
    logic                    wrap;
    logic                    start_ok;
    logic                    abort;
    logic                    burst_end;

    // Clamp at latch time: at least a 2-cycle period, and the pulse must
    // leave at least one low cycle so every period has a rising edge.
    always_comb begin
        length_ext   = PERIOD_WIDTH'(ipLength);
        start_period = (ipPeriod < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : ipPeriod;
        start_length = (length_ext >= start_period)
                     ? start_period - PERIOD_WIDTH'(1)
                     : length_ext;
    end

    assign wrap      = (phase == period - PERIOD_WIDTH'(1));
    assign phase_inc = wrap ? '0 : phase + PERIOD_WIDTH'(1);
    assign start_ok  = ipStart & ipEnable & ~ipStop;
    assign abort     = ipStop | ~ipEnable;
    // The last period of a finite burst ends once the B-th pulse's period completes.
    assign burst_end = wrap && (burst != '0) && (opPulseCount == burst);

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        period_n  = period;
        length_n  = length;
        burst_n   = burst;
        count_n   = opPulseCount;
        trigger_n = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n   = RUN;
                    period_n  = start_period;
                    length_n  = start_length;
                    burst_n   = ipBurstCount;
                    phase_n   = '0;
                    // Entering phase 0 is the first pulse.
                    count_n   = COUNT_WIDTH'(1);
                    trigger_n = (start_length != '0);
                    busy_n    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (burst_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    busy_n    = 1'b1;
                    phase_n   = phase_inc;
                    trigger_n = (phase_inc < length);
                    if (wrap && !(&opPulseCount)) begin
                        count_n = opPulseCount + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state        <= IDLE;
            phase        <= '0;
            period       <= '0;
            length       <= '0;
            burst        <= '0;
            opPulseCount <= '0;
            opTrigger    <= 1'b0;
            opBusy       <= 1'b0;
            opDone       <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            period       <= period_n;
            length       <= length_n;
            burst        <= burst_n;
            opPulseCount <= count_n;
            opTrigger    <= trigger_n;
            opBusy       <= busy_n;
            opDone       <= done_n;
        end
    end

endmodule
